// File: rtl/job_sequencer.sv
// job_sequencer: runs one accelerator job end to end.
// It streams operand bytes into data memory, pulses the core start request,
// waits for the core (bounded by a cycle timeout), then streams result bytes
// back out of data memory and signals job completion.
module job_sequencer #(
    parameter logic [7:0]  LD_BASE = 8'd0,
    parameter logic [8:0]  LD_CNT  = 9'd32,
    parameter logic [7:0]  UL_BASE = 8'd64,
    parameter logic [8:0]  UL_CNT  = 9'd32,
    parameter logic [11:0] TIMEOUT = 12'd4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_wr_en,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       req,
    input  logic       done,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       job_done,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LAUNCH,
        S_RUN,
        S_UNLOAD,
        S_FINISH
    } state_t;

    state_t      r_state;
    logic [8:0]  r_cnt;
    logic [11:0] r_tmr;
    logic        r_timeout_err;
    logic        r_req;
    logic        r_job_done;
    logic        r_busy;

    // Terminal-count comparisons; only evaluated in states where the count is non-zero.
    logic w_load_last;
    logic w_unload_last;
    logic w_tmr_last;

    assign w_load_last   = (r_cnt == (LD_CNT - 9'd1));
    assign w_unload_last = (r_cnt == (UL_CNT - 9'd1));
    assign w_tmr_last    = (r_tmr == (TIMEOUT - 12'd1));

    // Memory and stream handshakes depend on the current state and the live
    // input handshake. Reset gates them so a write cannot slip through on the
    // edge that aborts a load.
    always_comb begin
        in_ready  = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;
        out_valid = 1'b0;
        if (!reset) begin
            if (r_state == S_LOAD) begin
                in_ready  = 1'b1;
                mem_wr_en = in_valid;
                mem_addr  = LD_BASE + r_cnt[7:0];
                mem_wdata = in_data;
            end else if (r_state == S_UNLOAD) begin
                out_valid = 1'b1;
                mem_addr  = UL_BASE + r_cnt[7:0];
            end
        end
    end

    // The address only moves on a handshake, so read data stays put while stalled.
    assign out_data    = out_valid ? mem_rdata : 8'd0;
    assign req         = r_req;
    assign job_done    = r_job_done;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

    // Job FSM; req/job_done/busy are registered alongside the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 9'd0;
            r_tmr         <= 12'd0;
            r_timeout_err <= 1'b0;
            r_req         <= 1'b0;
            r_job_done    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_req      <= 1'b0;
            r_job_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt         <= 9'd0;
                        r_timeout_err <= 1'b0;
                        r_busy        <= 1'b1;
                        if (LD_CNT == 9'd0) begin
                            r_state <= S_LAUNCH;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_cnt <= r_cnt + 9'd1;
                        if (w_load_last) begin
                            r_state <= S_LAUNCH;
                            r_req   <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_tmr   <= 12'd0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    // Completion beats a timeout landing in the same cycle.
                    if (done) begin
                        r_cnt <= 9'd0;
                        if (UL_CNT == 9'd0) begin
                            r_state    <= S_FINISH;
                            r_job_done <= 1'b1;
                        end else begin
                            r_state <= S_UNLOAD;
                        end
                    end else if (w_tmr_last) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_FINISH;
                        r_job_done    <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr + 12'd1;
                    end
                end
                S_UNLOAD: begin
                    if (out_ready) begin
                        r_cnt <= r_cnt + 9'd1;
                        if (w_unload_last) begin
                            r_state    <= S_FINISH;
                            r_job_done <= 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_job_sequencer.sv
// Bench for job_sequencer: three instances with different parameter sets share
// the stimulus bus; only one is started at a time. Expected memory writes and
// result bytes are queued by the stimulus and consumed by a negedge monitor.
module tb_job_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       done;
    logic       out_ready;
    logic [2:0] start;
    logic [2:0] in_ready;
    logic [2:0] wr_en;
    logic [2:0] req;
    logic [2:0] out_valid;
    logic [2:0] busy;
    logic [2:0] job_done;
    logic [2:0] terr;
    logic [7:0] addr  [3];
    logic [7:0] wdata [3];
    logic [7:0] rdata [3];
    logic [7:0] odata [3];

    int checks   = 0;
    int failures = 0;
    logic [17:0] exp_wr [$];
    logic [9:0]  exp_out [$];
    int req_cnt [3] = '{0, 0, 0};
    int jd_cnt  [3] = '{0, 0, 0};
    int wr_cnt  [3] = '{0, 0, 0};
    int ov_cnt  [3] = '{0, 0, 0};

    // Result memory model: read data is a fixed pattern of the address.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rd
            assign rdata[gi] = addr[gi] ^ 8'hA5;
        end
    endgenerate

    job_sequencer #(.LD_BASE(8'd0), .LD_CNT(9'd4), .UL_BASE(8'd64), .UL_CNT(9'd2), .TIMEOUT(12'd16)) u_a (
        .clk(clk), .reset(reset), .start(start[0]), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[0]), .mem_wr_en(wr_en[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_rdata(rdata[0]), .req(req[0]), .done(done), .out_valid(out_valid[0]), .out_data(odata[0]),
        .out_ready(out_ready), .busy(busy[0]), .job_done(job_done[0]), .timeout_err(terr[0]));

    job_sequencer #(.LD_BASE(8'd254), .LD_CNT(9'd4), .UL_BASE(8'd64), .UL_CNT(9'd0), .TIMEOUT(12'd16)) u_b (
        .clk(clk), .reset(reset), .start(start[1]), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[1]), .mem_wr_en(wr_en[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_rdata(rdata[1]), .req(req[1]), .done(done), .out_valid(out_valid[1]), .out_data(odata[1]),
        .out_ready(out_ready), .busy(busy[1]), .job_done(job_done[1]), .timeout_err(terr[1]));

    job_sequencer #(.LD_BASE(8'd0), .LD_CNT(9'd0), .UL_BASE(8'd64), .UL_CNT(9'd1), .TIMEOUT(12'd16)) u_c (
        .clk(clk), .reset(reset), .start(start[2]), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[2]), .mem_wr_en(wr_en[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
        .mem_rdata(rdata[2]), .req(req[2]), .done(done), .out_valid(out_valid[2]), .out_data(odata[2]),
        .out_ready(out_ready), .busy(busy[2]), .job_done(job_done[2]), .timeout_err(terr[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=present required=absent", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits at negedges for req (0), job_done (1) or out_valid (2) of instance k.
    task automatic wait_for(input int k, input int which, input int budget, output int n);
        logic s;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            case (which)
                0:       s = req[k];
                1:       s = job_done[k];
                default: s = out_valid[k];
            endcase
            if (s) break;
            if (n >= budget) begin
                n = -1;
                break;
            end
        end
    endtask

    // Offers nb bytes (byte i in d[8i+:8]), optionally with an idle cycle before each.
    task automatic load(input int k, input logic [31:0] d, input int nb, input bit gaps);
        for (int i = 0; i < nb; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = d[8*i +: 8];
            @(negedge clk);
            for (int t = 0; !in_ready[k]; t++) begin
                if (t == 20) begin
                    checks++;
                    failures++;
                    $display("FAIL load_ready_timeout actual=0 required=1");
                    in_valid = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Monitor: consumes expected writes and result bytes, counts pulses.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (req[k]) req_cnt[k]++;
            if (job_done[k]) jd_cnt[k]++;
            if (wr_en[k]) begin
                wr_cnt[k]++;
                $display("write inst=%0d addr=%0d data=%0d", k, addr[k], wdata[k]);
                if (exp_wr.size() == 0) fail_now("write_unexpected");
                else check("write", {2'(k), addr[k], wdata[k]}, exp_wr.pop_front());
            end
            if (out_valid[k]) begin
                ov_cnt[k]++;
                if (exp_out.size() == 0) fail_now("out_unexpected");
                else begin
                    check("out_data", {2'(k), odata[k]}, exp_out[0]);
                    if (out_ready) begin
                        $display("result inst=%0d data=%0h", k, odata[k]);
                        void'(exp_out.pop_front());
                    end
                end
            end
            if (busy[k] === 1'b0) check("idle_bus", {addr[k], wdata[k]}, 16'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r0, j0, w0, o0;
        reset = 1'b1; start = 3'b000; in_valid = 1'b0; in_data = 8'd0;
        done = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("reset_ctrl", {in_ready, wr_en, req, out_valid, busy, job_done, terr}, 21'd0);
        check("reset_bus", {addr[0], addr[1], addr[2], wdata[0], wdata[1], wdata[2]}, 48'd0);

        // Nominal job on A; start held high during LOAD must be ignored.
        exp_wr.push_back({2'd0, 8'd0, 8'd11});
        exp_wr.push_back({2'd0, 8'd1, 8'd22});
        exp_wr.push_back({2'd0, 8'd2, 8'd33});
        exp_wr.push_back({2'd0, 8'd3, 8'd44});
        exp_out.push_back({2'd0, 8'hE5});
        exp_out.push_back({2'd0, 8'hE4});
        r0 = req_cnt[0]; j0 = jd_cnt[0]; w0 = wr_cnt[0];
        start[0] = 1'b1;
        tick();
        load(0, {8'd44, 8'd33, 8'd22, 8'd11}, 4, 1'b0);
        start[0] = 1'b0;
        wait_for(0, 0, 10, n);
        check("nom_req_latency", n, 1);
        tick();
        repeat (9) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_for(0, 1, 20, n);
        check("nom_unload_to_done", n, 3);
        tick();
        check("nom_req_pulses", req_cnt[0] - r0, 1);
        check("nom_done_pulses", jd_cnt[0] - j0, 1);
        check("nom_writes", wr_cnt[0] - w0, 4);
        check("nom_flags", {terr[0], busy[0]}, 2'b00);
        check("nom_queues_left", exp_wr.size() + exp_out.size(), 0);

        // Backpressure on A: gapped input, three stalled result cycles.
        exp_wr.push_back({2'd0, 8'd0, 8'd55});
        exp_wr.push_back({2'd0, 8'd1, 8'd66});
        exp_wr.push_back({2'd0, 8'd2, 8'd77});
        exp_wr.push_back({2'd0, 8'd3, 8'd88});
        exp_out.push_back({2'd0, 8'hE5});
        exp_out.push_back({2'd0, 8'hE4});
        w0 = wr_cnt[0]; o0 = ov_cnt[0];
        out_ready = 1'b0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        load(0, {8'd88, 8'd77, 8'd66, 8'd55}, 4, 1'b1);
        wait_for(0, 0, 10, n);
        check("bp_req_latency", n, 1);
        tick();
        repeat (2) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        wait_for(0, 1, 20, n);
        check("bp_unload_to_done", n, 3);
        tick();
        check("bp_writes", wr_cnt[0] - w0, 4);
        check("bp_out_valid_cycles", ov_cnt[0] - o0, 5);
        check("bp_queues_left", exp_wr.size() + exp_out.size(), 0);

        // Timeout on A: done never comes.
        exp_wr.push_back({2'd0, 8'd0, 8'd1});
        exp_wr.push_back({2'd0, 8'd1, 8'd2});
        exp_wr.push_back({2'd0, 8'd2, 8'd3});
        exp_wr.push_back({2'd0, 8'd3, 8'd4});
        o0 = ov_cnt[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        load(0, {8'd4, 8'd3, 8'd2, 8'd1}, 4, 1'b0);
        wait_for(0, 0, 10, n);
        check("to_req_latency", n, 1);
        wait_for(0, 1, 40, n);
        check("to_launch_to_done", n, 17);
        tick();
        check("to_err_set", terr[0], 1'b1);
        check("to_no_unload", ov_cnt[0] - o0, 0);

        // Next start clears the error; then reset lands mid-LOAD with data offered.
        exp_wr.push_back({2'd0, 8'd0, 8'd9});
        exp_wr.push_back({2'd0, 8'd1, 8'd8});
        w0 = wr_cnt[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("to_err_cleared", terr[0], 1'b0);
        load(0, {8'd0, 8'd7, 8'd8, 8'd9}, 2, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'd7;
        reset    = 1'b1;
        #1;
        check("rst_write_suppressed", wr_en[0], 1'b0);
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_outputs", {in_ready[0], wr_en[0], req[0], out_valid[0], busy[0], job_done[0], terr[0], addr[0], wdata[0]}, 23'd0);
        check("rst_writes", wr_cnt[0] - w0, 2);

        // Address wrap on B, no unload phase.
        exp_wr.push_back({2'd1, 8'd254, 8'hA1});
        exp_wr.push_back({2'd1, 8'd255, 8'hB2});
        exp_wr.push_back({2'd1, 8'd0,   8'hC3});
        exp_wr.push_back({2'd1, 8'd1,   8'hD4});
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        load(1, {8'hD4, 8'hC3, 8'hB2, 8'hA1}, 4, 1'b0);
        wait_for(1, 0, 10, n);
        check("wrap_req_latency", n, 1);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_for(1, 1, 5, n);
        check("wrap_done_latency", n, 1);
        tick();
        check("wrap_writes", wr_cnt[1], 4);
        check("wrap_no_unload", ov_cnt[1], 0);

        // Zero-length load on C goes straight to LAUNCH.
        exp_out.push_back({2'd2, 8'hE5});
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        wait_for(2, 0, 3, n);
        check("zero_req_latency", n, 1);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_for(2, 1, 10, n);
        check("zero_unload_to_done", n, 2);
        tick();
        check("zero_writes", wr_cnt[2], 0);
        check("zero_out_cycles", ov_cnt[2], 1);
        check("final_queues_left", exp_wr.size() + exp_out.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
